mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between the EX/MEM pipeline register and pipe_memory (MEM/WB).
- Turns ALU address, store data and load/store controls into a req/ack data-bus transaction, with byte-lane alignment and load sign/zero extension.
- Holds the pipeline via stall_M until the bus completes. Produces rd_data_M for pipe_memory.

Parameters:
- TIMEOUT_CYC, 64: max cycles in BUSY without dbus_ack before bus_err_M is raised.
- TO_W, 7: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall_in  in  1  global stall from hazard unit; the instruction remains in M.
- flush_in  in  1  kill the instruction currently in M.
- mem_rd_M  in  1  load.
- mem_wr_M  in  1  store; has priority over mem_rd_M if both are set.
- funct3_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is treated as W.
- alu_o_M  in  32  effective byte address.
- wr_data_M  in  32  store data (rs2).
- rd_data_M  out  32  formatted load result to pipe_memory.
- stall_M  out  1  stage-busy request to hazard unit.
- misaligned_M  out  1  misaligned access (combinational).
- bus_err_M  out  1  one-cycle timeout pulse.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write enable.
- dbus_addr  out  32  word address, bits [1:0] = 0.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-replicated store data.
- dbus_ack  in  1  transaction complete.
- dbus_rdata  in  32  read word, valid on the ack cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all dbus_* outputs, rd_data_M, bus_err_M, timeout counter and kill flag cleared.
  - A transaction in flight is abandoned; a late ack after reset release is ignored because the state is IDLE.
- op = (mem_rd_M | mem_wr_M) & !misaligned_M & !flush_in.
- misaligned_M:
  - 1 when H/HU and addr[0]=1, or W and addr[1:0]≠00.
  - When misaligned: no request, stall_M=0, rd_data_M=0.
- State IDLE:
  - If op: stall_M=1 combinationally in the same cycle; register addr, be, wdata, we, funct3 and addr[1:0]; go to BUSY.
  - Otherwise stall_M=0. rd_data_M=0 when no load is present.
- State BUSY:
  - dbus_req=1 with the registered fields, held stable until ack.
  - stall_M=1; the counter increments every cycle.
  - On dbus_ack:
    - For a load, format dbus_rdata into the result register; for a store, result=0.
    - Go to DONE, or to IDLE if the kill flag is set.
    - dbus_req drops the following cycle.
    - An ack in the first BUSY cycle is legal, giving a minimum of 2 stall cycles.
- Counter reaching TIMEOUT_CYC:
  - bus_err_M pulses for 1 cycle; result=0; go to DONE (or IDLE if killed).
  - dbus_req drops.
- flush_in during BUSY:
  - The bus transaction cannot be cancelled; set the kill flag and keep stall_M=1 until ack or timeout.
  - Then go to IDLE, discarding the data. bus_err_M is still reported on timeout.
- State DONE:
  - stall_M=0; rd_data_M=result register.
  - Remain in DONE while stall_in=1, so the same instruction is not reissued.
  - On stall_in=0, go to IDLE; the instruction advances.
  - flush_in in DONE: go to IDLE, rd_data_M=0.
- Lane rules, with o = addr[1:0]:
  - SB: be=0001<<o; wdata = byte replicated ×4.
  - SH: be = o[1] ? 1100 : 0011; wdata = half replicated ×2.
  - SW: be=1111.
  - Loads: be=1111.
  - LB/LBU: select byte o, then sign/zero extend.
  - LH/LHU: select half o[1], then sign/zero extend.

Decomposition:
- Package mem_pkg:
  - enum mem_state_t {IDLE, BUSY, DONE}.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - packed struct bus_req_t {we, addr, be, wdata}.
- One combinational sub-module, lsu_align: generates be/wdata and formats load data. The FSM, counter and kill flag stay in mem_access_stage.

Test Plan:
- LW at 0x100, ack on 2nd BUSY cycle, rdata=0xDEADBEEF -> dbus_addr=0x100, be=1111, stall_M high for 3 cycles, rd_data_M=0xDEADBEEF in DONE.
- LB at 0x103 with rdata=0x80FF_FF_FF -> rd_data_M=0xFFFFFF80. LBU same -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SB at 0x201, wr_data=0x000000A5 -> dbus_addr=0x200, be=0010, wdata=0xA5A5A5A5, we=1. SH at 0x202 -> be=1100.
- LW at 0x102 -> misaligned_M=1, dbus_req never asserted, stall_M=0.
- flush_in in the 1st BUSY cycle, ack 3 cycles later -> stall_M held until ack, then IDLE, rd_data_M=0. stall_in=1 across DONE -> exactly one bus transaction issued.
- No ack for TIMEOUT_CYC=64 cycles -> bus_err_M one-cycle pulse, rd_data_M=0. rst low mid-BUSY -> dbus_req=0 immediately (asynchronous), state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the RV32I memory-access stage:
// FSM states, funct3 access-size codes and the registered bus request.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    f3_unsigned = (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for stores and lane selection plus sign/zero
// extension for loads. Purely combinational.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic        st_we_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    if (st_we_i) begin
      case (f3_size(st_f3_i))
        SZ_B: begin
          be_o    = 4'b0001 << st_off_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        SZ_H: begin
          be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: be_o = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ldByte = ld_rdata_i[7:0];
      2'd1:    ldByte = ld_rdata_i[15:8];
      2'd2:    ldByte = ld_rdata_i[23:16];
      default: ldByte = ld_rdata_i[31:24];
    endcase
    ldHalf = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (f3_size(ld_f3_i))
      SZ_B:    ld_data_o = f3_unsigned(ld_f3_i) ? {24'h0, ldByte}
                                                : {{24{ldByte[7]}}, ldByte};
      SZ_H:    ld_data_o = f3_unsigned(ld_f3_i) ? {16'h0, ldHalf}
                                                : {{16{ldHalf[15]}}, ldHalf};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: issues one req/ack bus transaction per
// load/store, stalls the pipeline until it completes and formats load data.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  output logic [31:0] rd_data_M,
  output logic        stall_M,
  output logic        misaligned_M,
  output logic        bus_err_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  mem_state_t      state_q, state_d;
  bus_req_t        req_q, req_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic [31:0]     result_q, result_d;
  logic            busErr_q, busErr_d;

  logic [3:0]  beNew;
  logic [31:0] wdataNew;
  logic [31:0] ldFmt;
  logic        op;
  acc_size_t   curSize;

  lsu_align u_align (
    .st_f3_i    (funct3_M),
    .st_off_i   (alu_o_M[1:0]),
    .st_we_i    (mem_wr_M),
    .st_data_i  (wr_data_M),
    .be_o       (beNew),
    .wdata_o    (wdataNew),
    .ld_f3_i    (f3_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (dbus_rdata),
    .ld_data_o  (ldFmt)
  );

  assign curSize      = f3_size(funct3_M);
  assign misaligned_M = (mem_rd_M | mem_wr_M) &
                        (((curSize == SZ_H) & alu_o_M[0]) |
                         ((curSize == SZ_W) & (alu_o_M[1:0] != 2'b00)));
  assign op = (mem_rd_M | mem_wr_M) & ~misaligned_M & ~flush_in;

  assign dbus_req   = (state_q == BUSY);
  assign dbus_we    = req_q.we;
  assign dbus_addr  = req_q.addr;
  assign dbus_be    = req_q.be;
  assign dbus_wdata = req_q.wdata;
  assign bus_err_M  = busErr_q;

  // A flushed transaction still has to finish on the bus, so the kill flag
  // only decides whether the result is delivered or discarded afterwards.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    f3_d      = f3_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    result_d  = result_q;
    busErr_d  = 1'b0;
    stall_M   = 1'b0;
    rd_data_M = 32'h0;
    case (state_q)
      IDLE: begin
        if (op) begin
          stall_M = 1'b1;
          req_d   = '{we: mem_wr_M, addr: {alu_o_M[31:2], 2'b00},
                      be: beNew, wdata: wdataNew};
          f3_d    = funct3_M;
          off_d   = alu_o_M[1:0];
          cnt_d   = '0;
          kill_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_M = 1'b1;
        cnt_d   = cnt_q + TO_W'(1);
        kill_d  = kill_q | flush_in;
        if (dbus_ack) begin
          result_d = req_q.we ? 32'h0 : ldFmt;
          state_d  = kill_d ? IDLE : DONE;
        end else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          busErr_d = 1'b1;
          result_d = 32'h0;
          state_d  = kill_d ? IDLE : DONE;
        end
      end
      DONE: begin
        rd_data_M = flush_in ? 32'h0 : result_q;
        if (flush_in || !stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      f3_q     <= 3'b0;
      off_q    <= 2'b0;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      result_q <= 32'h0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      result_q <= result_d;
      busErr_q <= busErr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: loads, stores,
// misalignment, flush, pipeline stall in DONE, bus timeout and async reset.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        flush_in;
  logic        mem_rd_M;
  logic        mem_wr_M;
  logic [2:0]  funct3_M;
  logic [31:0] alu_o_M;
  logic [31:0] wr_data_M;
  logic [31:0] rd_data_M;
  logic        stall_M;
  logic        misaligned_M;
  logic        bus_err_M;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int tests;
  int fails;

  logic [31:0] capAddr, capWdata, capResult;
  logic [3:0]  capBe;
  logic        capWe, capDoneStall, capDoneReq;
  int          capStalls, capReqs;

  mem_access_stage #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .mem_rd_M     (mem_rd_M),
    .mem_wr_M     (mem_wr_M),
    .funct3_M     (funct3_M),
    .alu_o_M      (alu_o_M),
    .wr_data_M    (wr_data_M),
    .rd_data_M    (rd_data_M),
    .stall_M      (stall_M),
    .misaligned_M (misaligned_M),
    .bus_err_M    (bus_err_M),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one access with the ack in BUSY cycle ackCycle and records what the
  // bus and pipeline saw; the DONE cycle has stall_in low.
  task automatic run_access(input logic isWr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ackCycle);
    @(posedge clk); #1;
    mem_rd_M = !isWr; mem_wr_M = isWr; funct3_M = f3;
    alu_o_M = addr; wr_data_M = wdata; dbus_ack = 1'b0;
    capStalls = 0; capReqs = 0; capAddr = '0; capBe = '0; capWe = 1'b0; capWdata = '0;
    @(negedge clk);
    if (stall_M) capStalls++;
    for (int b = 1; b <= ackCycle; b++) begin
      @(posedge clk); #1;
      if (b == ackCycle) begin dbus_ack = 1'b1; dbus_rdata = rdata; end
      @(negedge clk);
      if (stall_M) capStalls++;
      if (dbus_req) begin
        capReqs++; capAddr = dbus_addr; capBe = dbus_be; capWe = dbus_we; capWdata = dbus_wdata;
      end
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = 32'h0BAD0BAD; mem_rd_M = 1'b0; mem_wr_M = 1'b0;
    @(negedge clk);
    capResult = rd_data_M; capDoneStall = stall_M; capDoneReq = dbus_req;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_in = 1'b0; flush_in = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0;
    funct3_M = 3'b0; alu_o_M = '0; wr_data_M = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    #12;
    tests++;
    if ({dbus_req, dbus_we, dbus_be, stall_M, bus_err_M} !== 8'h00 ||
        dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || rd_data_M !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: req=%b be=%h addr=%h rd=%h stall=%b err=%b, need all 0",
               dbus_req, dbus_be, dbus_addr, rd_data_M, stall_M, bus_err_M);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    tests++;
    if (capAddr !== 32'h100 || capBe !== 4'b1111 || capWe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lw_bus: addr=%h be=%b we=%b, need 00000100 1111 0", capAddr, capBe, capWe);
    end
    tests++;
    if (capStalls != 3 || capReqs != 2) begin
      fails++;
      $display("[TB] FAIL lw_stall: stalls=%0d reqs=%0d, need 3 and 2", capStalls, capReqs);
    end
    tests++;
    if (capResult !== 32'hDEADBEEF || capDoneStall !== 1'b0 || capDoneReq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lw_done: rd=%h stall=%b req=%b, need deadbeef 0 0",
               capResult, capDoneStall, capDoneReq);
    end
    @(negedge clk);
    tests++;
    if (rd_data_M !== 32'h0 || stall_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lw_idle: rd=%h stall=%b, need 0 0", rd_data_M, stall_M);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
    logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] rds   [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF,
                               32'h80FFFF7F, 32'h12348001};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                               32'h0000007F, 32'hFFFF8001};
    for (int i = 0; i < 6; i++) begin
      run_access(1'b0, f3s[i], addrs[i], 32'h0, rds[i], 1);
      tests++;
      if (capResult !== exps[i] || capAddr !== 32'h100 || capStalls != 2) begin
        fails++;
        $display("[TB] FAIL load_%0d: rd=%h addr=%h stalls=%0d, need %h 00000100 2",
                 i, capResult, capAddr, capStalls, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s   [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] addrs [3] = '{32'h201, 32'h202, 32'h300};
    logic [31:0] wds   [3] = '{32'h000000A5, 32'h1234BEEF, 32'hCAFEF00D};
    logic [31:0] eAddr [3] = '{32'h200, 32'h200, 32'h300};
    logic [3:0]  eBe   [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] eWd   [3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, f3s[i], addrs[i], wds[i], 32'hFFFFFFFF, 1);
      tests++;
      if (capAddr !== eAddr[i] || capBe !== eBe[i] || capWdata !== eWd[i] ||
          capWe !== 1'b1 || capResult !== 32'h0) begin
        fails++;
        $display("[TB] FAIL store_%0d: addr=%h be=%b wd=%h we=%b rd=%h, need %h %b %h 1 0",
                 i, capAddr, capBe, capWdata, capWe, capResult, eAddr[i], eBe[i], eWd[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    int reqs = 0;
    int bad = 0;
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h102;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dbus_req) reqs++;
      if (misaligned_M !== 1'b1 || stall_M !== 1'b0 || rd_data_M !== 32'h0) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (reqs != 0 || bad != 0) begin
      fails++;
      $display("[TB] FAIL misaligned_lw: reqs=%0d bad_cycles=%0d, need 0 0", reqs, bad);
    end
    mem_rd_M = 1'b0; mem_wr_M = 1'b1; funct3_M = 3'b001; alu_o_M = 32'h203;
    @(negedge clk);
    tests++;
    if (misaligned_M !== 1'b1 || stall_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misaligned_sh: mis=%b stall=%b, need 1 0", misaligned_M, stall_M);
    end
    @(posedge clk); #1;
    mem_wr_M = 1'b0; mem_rd_M = 1'b1; funct3_M = 3'b101; alu_o_M = 32'h102; flush_in = 1'b1;
    @(negedge clk);
    tests++;
    if (misaligned_M !== 1'b0 || stall_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL aligned_lhu_flushed: mis=%b stall=%b, need 0 0", misaligned_M, stall_M);
    end
    @(posedge clk); #1;
    mem_rd_M = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    tests++;
    if (dbus_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL no_req_after_flush: req=%b, need 0", dbus_req);
    end
  endtask

  task automatic test_flush_busy();
    int stalls = 0;
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h100;
    @(posedge clk); #1;
    flush_in = 1'b1;
    @(negedge clk);
    if (stall_M) stalls++;
    @(posedge clk); #1;
    flush_in = 1'b0; mem_rd_M = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      if (b == 4) begin dbus_ack = 1'b1; dbus_rdata = 32'h11111111; end
      @(negedge clk);
      if (stall_M && dbus_req) stalls++;
      @(posedge clk); #1;
    end
    dbus_ack = 1'b0;
    tests++;
    if (stalls != 4) begin
      fails++;
      $display("[TB] FAIL flush_stall_held: stall_cycles=%0d, need 4", stalls);
    end
    @(negedge clk);
    tests++;
    if (stall_M !== 1'b0 || rd_data_M !== 32'h0 || dbus_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_discard: stall=%b rd=%h req=%b, need 0 0 0", stall_M, rd_data_M, dbus_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_done();
    int reqs = 0;
    int bad = 0;
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h180;
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'h0C0FFEE0;
    @(negedge clk);
    if (dbus_req) reqs++;
    @(posedge clk); #1;
    dbus_ack = 1'b0; stall_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) stall_in = 1'b0;
      @(negedge clk);
      if (dbus_req) reqs++;
      if (rd_data_M !== 32'h0C0FFEE0 || stall_M !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    mem_rd_M = 1'b0;
    @(negedge clk);
    if (dbus_req) reqs++;
    tests++;
    if (reqs != 1 || bad != 0) begin
      fails++;
      $display("[TB] FAIL stall_in_done: reqs=%0d bad_cycles=%0d, need 1 0", reqs, bad);
    end
    run_access(1'b0, 3'b010, 32'h184, 32'h0, 32'h55AA55AA, 1);
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h188;
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'h77777777;
    @(posedge clk); #1;
    dbus_ack = 1'b0; stall_in = 1'b1; flush_in = 1'b1; mem_rd_M = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_data_M !== 32'h0) begin
      fails++;
      $display("[TB] FAIL flush_in_done: rd=%h, need 0", rd_data_M);
    end
    @(posedge clk); #1;
    flush_in = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_data_M !== 32'h0 || stall_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_done_flush: rd=%h stall=%b, need 0 0", rd_data_M, stall_M);
    end
    @(posedge clk); #1;
    stall_in = 1'b0;
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    int errEarly = 0;
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h400;
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!dbus_req) break;
      reqCycles++;
      if (bus_err_M) errEarly++;
    end
    tests++;
    if (reqCycles != 64 || errEarly != 0) begin
      fails++;
      $display("[TB] FAIL timeout_len: busy_cycles=%0d early_err=%0d, need 64 0", reqCycles, errEarly);
    end
    tests++;
    if (bus_err_M !== 1'b1 || rd_data_M !== 32'h0 || stall_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_done: err=%b rd=%h stall=%b, need 1 0 0", bus_err_M, rd_data_M, stall_M);
    end
    @(posedge clk); #1;
    mem_rd_M = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_err_M !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_pulse: err=%b, need 0", bus_err_M);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    mem_rd_M = 1'b1; funct3_M = 3'b010; alu_o_M = 32'h500;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (dbus_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_reset_busy: req=%b, need 1", dbus_req);
    end
    #2;
    rst = 1'b0; mem_rd_M = 1'b0;
    #1;
    tests++;
    if (dbus_req !== 1'b0 || stall_M !== 1'b0 || dbus_be !== 4'b0 || dbus_addr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL async_reset: req=%b stall=%b be=%b addr=%h, need 0 0 0 0",
               dbus_req, stall_M, dbus_be, dbus_addr);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    tests++;
    if (dbus_req !== 1'b0 || stall_M !== 1'b0 || rd_data_M !== 32'h0) begin
      fails++;
      $display("[TB] FAIL late_ack_ignored: req=%b stall=%b rd=%h, need 0 0 0",
               dbus_req, stall_M, rd_data_M);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misaligned();
    test_flush_busy();
    test_stall_done();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
